// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO input unit.
// Holds the word register index map, the default pin count, and the bus address type.
// Imported by the interface and by the top level.
package gpio_pkg;

   typedef logic [1:0] gpio_addr_t;

   localparam gpio_addr_t GPIO_ADDR_DATA = 2'd0;
   localparam gpio_addr_t GPIO_ADDR_EDGE = 2'd1;
   localparam gpio_addr_t GPIO_ADDR_MASK = 2'd2;

   localparam int GPIO_WIDTH = 8;

endpackage

// File: rtl/gpio_input_unit_if.sv
// Word-wide load/store port between the core (master) and the GPIO unit (slave).
// Signals: rd_en/wr_en strobes, addr word index, wdata write data, rdata combinational read data.
// No handshake: every access completes in the cycle it is presented.
interface gpio_input_unit_if;
   import gpio_pkg::*;

   logic        rd_en;
   logic        wr_en;
   gpio_addr_t  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd_en, output wr_en, output addr, output wdata, input rdata);
   modport slave  (input rd_en, input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchronizer, stability counter and debounced level register.
// Latency: level_o follows a held pin change after DEBOUNCE_CYCLES+2 rising edges.
// No backpressure; change_o is a one-cycle pulse asserted in the cycle before level_o flips.
// Ports: clk, rst (async active-low), pin_i raw pin, level_o debounced level, change_o pulse.
module gpio_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic level_o,
   output logic change_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronized pin agrees with q restarts the count,
   // so only an uninterrupted run of DEBOUNCE_CYCLES mismatches is accepted.
   always_comb begin
      q_d      = q_q;
      cnt_d    = '0;
      change_o = 1'b0;
      if (s2_q != q_q) begin
         if (cnt_q == CNT_MAX) begin
            q_d      = s2_q;
            change_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         q_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= pin_i;
         s2_q  <= s1_q;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = q_q;
endmodule

// File: rtl/gpio_input_unit.sv
// Debounced GPIO input peripheral with sticky W1C change flags, read over a word-wide port.
// Latency: pin to DATA in DEBOUNCE_CYCLES+2 edges; reads are combinational, writes land at the write edge.
// No backpressure: accesses never stall. Macro GPIO_IRQ_EN adds the MASK register and irq.
// Ports: clk, rst (async active-low), pins_i raw pins, bus (slave port), gpio_o debounced level, irq.
module gpio_input_unit
   import gpio_pkg::*;
#(
   parameter int WIDTH           = GPIO_WIDTH,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  pins_i,
   gpio_input_unit_if.slave  bus,
   output logic [WIDTH-1:0]  gpio_o,
   output logic              irq
);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] change;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] mask_rd;
   logic [31:0]      rdata_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk      (clk),
         .rst      (rst),
         .pin_i    (pins_i[i]),
         .level_o  (q[i]),
         .change_o (change[i])
      );
   end

   // Set is ORed in after the clear so a fresh change survives a same-cycle W1C.
   always_comb begin
      clr    = (bus.wr_en && bus.addr == GPIO_ADDR_EDGE) ? bus.wdata[WIDTH-1:0] : '0;
      edge_d = (edge_q & ~clr) | change;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) edge_q <= '0;
      else      edge_q <= edge_d;
   end

`ifdef GPIO_IRQ_EN
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             irq_q, irq_d;

   always_comb begin
      mask_d = mask_q;
      if (bus.wr_en && bus.addr == GPIO_ADDR_MASK) mask_d = bus.wdata[WIDTH-1:0];
      irq_d = |(edge_q & mask_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign mask_rd = mask_q;
   assign irq     = irq_q;
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

   // Read mux sees register outputs only, so a same-cycle write reads back the old value.
   always_comb begin
      rdata_c = '0;
      if (bus.rd_en) begin
         case (bus.addr)
            GPIO_ADDR_DATA: rdata_c = 32'(q);
            GPIO_ADDR_EDGE: rdata_c = 32'(edge_q);
            GPIO_ADDR_MASK: rdata_c = 32'(mask_rd);
            default:        rdata_c = '0;
         endcase
      end
   end

   assign bus.rdata = rdata_c;
   assign gpio_o    = q;

   // Upper write-data bits beyond WIDTH carry no state.
   wire unused_wdata = ^bus.wdata;
endmodule

// File: tb/tb_gpio_input_unit.sv
module tb_gpio_input_unit;
   import gpio_pkg::*;

`ifdef GPIO_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pins_i;
   logic [7:0] gpio_o;
   logic       irq;

   gpio_input_unit_if bus ();

   gpio_input_unit #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .pins_i (pins_i),
      .bus    (bus),
      .gpio_o (gpio_o),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Scoreboard: expectation pushed when the stimulus is set up, popped when the output is sampled.
   string       sb_tag[$];
   logic [31:0] sb_val[$];

   task automatic push_exp(input string tag, input logic [31:0] v);
      sb_tag.push_back(tag);
      sb_val.push_back(v);
   endtask

   task automatic check_obs(input logic [31:0] obs);
      string       tag;
      logic [31:0] exp;
      tests++;
      if (sb_val.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty: got %h required an expectation", obs);
      end else begin
         tag = sb_tag.pop_front();
         exp = sb_val.pop_front();
         assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called 1 time unit after a rising edge; samples well before the next edge.
   task automatic rd(input gpio_addr_t a, input logic [31:0] exp, input string tag);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      push_exp(tag, exp);
      #2;
      check_obs(bus.rdata);
      bus.rd_en = 1'b0;
   endtask

   task automatic wr(input gpio_addr_t a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic chk_gpio(input logic [7:0] exp, input string tag);
      push_exp(tag, 32'(exp));
      check_obs(32'(gpio_o));
   endtask

   task automatic chk_irq(input logic exp, input string tag);
      push_exp(tag, 32'(exp));
      check_obs(32'(irq));
   endtask

   initial begin
      rst       = 1'b0;
      pins_i    = 8'hFF;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.addr  = GPIO_ADDR_DATA;
      bus.wdata = '0;
      ticks(2);

      // Reset held with all pins high
      chk_gpio(8'h00, "rst_gpio");
      chk_irq(1'b0, "rst_irq");
      rd(2'd0, 32'h0, "rst_data");
      rd(2'd1, 32'h0, "rst_edge");
      rd(2'd2, 32'h0, "rst_mask");
      rd(2'd3, 32'h0, "rst_rsvd");
      bus.addr = GPIO_ADDR_DATA;
      push_exp("rdata_idle", 32'h0);
      check_obs(bus.rdata);

      // Release: level appears after exactly 6 edges
      rst = 1'b1;
      ticks(5);
      chk_gpio(8'h00, "rel_gpio_e4");
      tick();
      chk_gpio(8'hFF, "rel_gpio_e5");
      rd(GPIO_ADDR_EDGE, 32'hFF, "rel_edge");
      wr(GPIO_ADDR_EDGE, 32'hFF);
      rd(GPIO_ADDR_EDGE, 32'h0, "rel_edge_clr");

      // Return all pins low
      pins_i = 8'h00;
      ticks(6);
      chk_gpio(8'h00, "fall_gpio");
      rd(GPIO_ADDR_EDGE, 32'hFF, "fall_edge");
      wr(GPIO_ADDR_EDGE, 32'hFF);

      // Glitch: 3-cycle pulse on bit 0 is rejected
      pins_i = 8'h01;
      ticks(3);
      pins_i = 8'h00;
      ticks(8);
      chk_gpio(8'h00, "glitch_gpio");
      rd(GPIO_ADDR_EDGE, 32'h0, "glitch_edge");

      // Accepted change
      pins_i = 8'h05;
      ticks(5);
      rd(GPIO_ADDR_DATA, 32'h0, "acc_data_e4");
      tick();
      rd(GPIO_ADDR_DATA, 32'h5, "acc_data_e5");
      chk_gpio(8'h05, "acc_gpio");
      rd(GPIO_ADDR_EDGE, 32'h05, "acc_edge");

      // Writes to DATA and the reserved slot are ignored
      wr(GPIO_ADDR_DATA, 32'hFF);
      rd(GPIO_ADDR_DATA, 32'h5, "data_ro");
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, 32'h0, "rsvd_ro");

      // W1C on bit 0 only
      wr(GPIO_ADDR_EDGE, 32'h01);
      rd(GPIO_ADDR_EDGE, 32'h04, "w1c_bit0");

      // Clear of bit 2 lands on the same edge as a new bit-2 change: set wins
      pins_i = 8'h01;
      ticks(5);
      wr(GPIO_ADDR_EDGE, 32'h04);
      chk_gpio(8'h01, "simul_gpio");
      rd(GPIO_ADDR_EDGE, 32'h04, "simul_edge");

      // Interrupt: mask bit 2 while its flag is set
      wr(GPIO_ADDR_MASK, 32'h04);
      chk_irq(1'b0, "irq_at_mask_edge");
      tick();
      chk_irq(IRQ_ON, "irq_after_mask");
      rd(GPIO_ADDR_MASK, IRQ_ON ? 32'h04 : 32'h0, "mask_read");

      // Simultaneous read and W1C: read returns the pre-write flags
      bus.addr  = GPIO_ADDR_EDGE;
      bus.wdata = 32'h04;
      bus.rd_en = 1'b1;
      bus.wr_en = 1'b1;
      push_exp("rdwr_prewrite", 32'h04);
      #2;
      check_obs(bus.rdata);
      tick();
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      rd(GPIO_ADDR_EDGE, 32'h0, "rdwr_cleared");
      chk_irq(IRQ_ON, "irq_at_clr_edge");
      tick();
      chk_irq(1'b0, "irq_after_clr");

      // Reset in mid-debounce discards the partial count
      pins_i = 8'h03;
      ticks(3);
      rst = 1'b0;
      #1;
      chk_gpio(8'h00, "mid_rst_gpio");
      tick();
      rst = 1'b1;
      ticks(5);
      chk_gpio(8'h00, "mid_rel_e4");
      tick();
      chk_gpio(8'h03, "mid_rel_e5");
      rd(GPIO_ADDR_EDGE, 32'h03, "mid_rel_edge");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
